// File: rtl/mpu_frame_assembler.sv
// rtl/mpu_frame_assembler.sv - assembles one MPU6050 burst into seven signed 16-bit words
module mpu_frame_assembler #(
    parameter int FRAME_BYTES = 14,
    parameter int TIMEOUT_CYC = 500000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             read_done,
    input  logic             data_avalid,
    input  logic [7:0]       data,
    output logic [15:0]      accel_x,
    output logic [15:0]      accel_y,
    output logic [15:0]      accel_z,
    output logic [15:0]      temp_raw,
    output logic [15:0]      gyro_x,
    output logic [15:0]      gyro_y,
    output logic [15:0]      gyro_z,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BC_W = $clog2(FRAME_BYTES + 1);
    localparam int TM_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_BYTES);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_SHORT   = 2'b00;
    localparam logic [1:0] ERR_LONG    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RESTART = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [7:0]      shadow [0:FRAME_BYTES-1];
    logic [BC_W-1:0] byte_cnt;
    logic [TM_W-1:0] timer;
    logic            ovf;

    // Control decoded from the FSM, applied by the datapath register block
    logic       clr_collect;
    logic       store_byte;
    logic       set_ovf;
    logic       clr_timer;
    logic       inc_timer;
    logic       commit_ok;
    logic       err_now;
    logic [1:0] err_code_now;

    assign busy = (state == COLLECT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control; frame_start outranks read_done, which outranks timeout
    always_comb begin
        state_next   = state;
        clr_collect  = 1'b0;
        store_byte   = 1'b0;
        set_ovf      = 1'b0;
        clr_timer    = 1'b0;
        inc_timer    = 1'b0;
        commit_ok    = 1'b0;
        err_now      = 1'b0;
        err_code_now = ERR_SHORT;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    clr_collect = 1'b1;
                    state_next  = COLLECT;
                end
            end
            COLLECT: begin
                if (frame_start) begin
                    err_now      = 1'b1;
                    err_code_now = ERR_RESTART;
                    clr_collect  = 1'b1;
                end else begin
                    // A byte coinciding with read_done is still stored or counted
                    if (data_avalid) begin
                        clr_timer = 1'b1;
                        if (byte_cnt < BC_FULL) begin
                            store_byte = 1'b1;
                        end else begin
                            set_ovf = 1'b1;
                        end
                    end
                    if (read_done) begin
                        state_next = COMMIT;
                    end else if (!data_avalid) begin
                        if (timer == TM_LAST) begin
                            err_now      = 1'b1;
                            err_code_now = ERR_TIMEOUT;
                            state_next   = IDLE;
                        end else begin
                            inc_timer = 1'b1;
                        end
                    end
                end
            end
            COMMIT: begin
                if (ovf) begin
                    err_now      = 1'b1;
                    err_code_now = ERR_LONG;
                end else if (byte_cnt == BC_FULL) begin
                    commit_ok = 1'b1;
                end else begin
                    err_now      = 1'b1;
                    err_code_now = ERR_SHORT;
                end
                // A new frame_start during commit reopens collection immediately
                clr_collect = frame_start;
                state_next  = frame_start ? COLLECT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shadow buffer, counters, strobes and the atomically committed output words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                shadow[i] <= 8'h00;
            end
            byte_cnt    <= '0;
            timer       <= '0;
            ovf         <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            frame_cnt   <= '0;
            accel_x     <= 16'h0000;
            accel_y     <= 16'h0000;
            accel_z     <= 16'h0000;
            temp_raw    <= 16'h0000;
            gyro_x      <= 16'h0000;
            gyro_y      <= 16'h0000;
            gyro_z      <= 16'h0000;
        end else begin
            frame_valid <= commit_ok;
            frame_err   <= err_now;
            if (err_now) begin
                err_code <= err_code_now;
            end
            if (clr_collect) begin
                byte_cnt <= '0;
                ovf      <= 1'b0;
                timer    <= '0;
            end else begin
                if (store_byte) begin
                    shadow[byte_cnt] <= data;
                    byte_cnt         <= byte_cnt + BC_W'(1);
                end
                if (set_ovf) begin
                    ovf <= 1'b1;
                end
                if (clr_timer) begin
                    timer <= '0;
                end else if (inc_timer) begin
                    timer <= timer + TM_W'(1);
                end
            end
            if (commit_ok) begin
                accel_x   <= {shadow[0],  shadow[1]};
                accel_y   <= {shadow[2],  shadow[3]};
                accel_z   <= {shadow[4],  shadow[5]};
                temp_raw  <= {shadow[6],  shadow[7]};
                gyro_x    <= {shadow[8],  shadow[9]};
                gyro_y    <= {shadow[10], shadow[11]};
                gyro_z    <= {shadow[12], shadow[13]};
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule
